// File: rtl/ir_err_pkg.sv
// ir_err_pkg: shared types and widths for the IR line-error stage.
//   state_t : FSM state encoding (IDLE, ACCUM, FINAL)
//   IR_W    : sensor reading width / err width
//   DIFF_W  : signed per-pair difference width
//   ACC_W   : signed accumulator width (holds +/-4095*15 without overflow)
//   ERR_MAX/ERR_MIN : 12-bit signed clamp limits
package ir_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam int IR_W    = 12;
    localparam int DIFF_W  = 13;
    localparam int ACC_W   = 18;
    localparam int ERR_MAX = 2047;
    localparam int ERR_MIN = -2048;

endpackage

// File: rtl/ir_err_calc_sat.sv
// err_sat: combinational clamp of the signed accumulator to a 12-bit signed value.
// Ports:
//   acc (in,  ACC_W) signed accumulator
//   sat (out, IR_W)  acc clipped to [ERR_MIN, ERR_MAX]
module err_sat
    import ir_err_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [IR_W-1:0]  sat
);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(ERR_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(ERR_MIN);

    always_comb begin
        sat = acc[IR_W-1:0];
        if ($signed(acc) > SAT_HI) begin
            sat = IR_W'(ERR_MAX);
        end else if ($signed(acc) < SAT_LO) begin
            sat = IR_W'(ERR_MIN);
        end
    end

endmodule

// File: rtl/ir_err_calc.sv
// ir_err_calc: weighted right-minus-left line error from eight IR readings.
// On IR_vld the readings are snapshotted, four weighted differences (1,2,4,8)
// are accumulated over four cycles, the sum is clamped to 12 bits, lost-line
// recovery is applied, and err is presented with a one-cycle err_vld strobe.
// Optional macro ERR_FILT_EN adds an IIR smoother on err (shift FILT_SHIFT).
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   IR_vld             one-cycle pulse: new sensor round
//   line_present       line detected flag, sampled when err is loaded
//   IR_R0..IR_R3       right readings (R0 innermost)
//   IR_L0..IR_L3       left readings (L0 innermost)
//   err                signed error, +ve = line to the right
//   err_vld            one-cycle strobe: err updated
//   busy               computation in progress
//   ovr                sticky: IR_vld seen while busy
//
// state | meaning
// IDLE  | waiting for IR_vld; snapshot taken on acceptance
// ACCUM | adding weighted pair idx into acc, idx 0..3
// FINAL | clamp, lost-line select, load err, pulse err_vld
module ir_err_calc
    import ir_err_pkg::*;
#(
    parameter logic signed [IR_W-1:0] LOST_MAG = 12'sd1536
`ifdef ERR_FILT_EN
    ,
    parameter int FILT_SHIFT = 2
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            IR_vld,
    input  logic            line_present,
    input  logic [IR_W-1:0] IR_R0,
    input  logic [IR_W-1:0] IR_R1,
    input  logic [IR_W-1:0] IR_R2,
    input  logic [IR_W-1:0] IR_R3,
    input  logic [IR_W-1:0] IR_L0,
    input  logic [IR_W-1:0] IR_L1,
    input  logic [IR_W-1:0] IR_L2,
    input  logic [IR_W-1:0] IR_L3,
    output logic [IR_W-1:0] err,
    output logic            err_vld,
    output logic            busy,
    output logic            ovr
);

    state_t state, state_nxt;

    logic [IR_W-1:0]         r_snap [4];
    logic [IR_W-1:0]         l_snap [4];
    logic [1:0]              idx;
    logic signed [ACC_W-1:0] acc;
    logic                    last_sign;

    logic                    load;
    logic signed [DIFF_W-1:0] diff;
    logic signed [ACC_W-1:0] term;
    logic [IR_W-1:0]         sat;
    logic [IR_W-1:0]         lost_val;
    logic [IR_W-1:0]         v;
    logic [IR_W-1:0]         err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        load      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (IR_vld) begin
                    load      = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (idx == 2'd3) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Readings are unsigned, so zero-extend before subtracting.
    always_comb begin
        diff = $signed({1'b0, r_snap[idx]}) - $signed({1'b0, l_snap[idx]});
        term = $signed({{(ACC_W-DIFF_W){diff[DIFF_W-1]}}, diff}) <<< idx;
    end

    err_sat u_sat (
        .acc (acc),
        .sat (sat)
    );

    always_comb begin
        lost_val = last_sign ? -LOST_MAG : LOST_MAG;
        v        = line_present ? sat : lost_val;
    end

`ifdef ERR_FILT_EN
    logic signed [IR_W:0] delta;
    logic signed [IR_W:0] step;

    // 13-bit working width: v - err spans +/-4095, and err + step stays in 12-bit range.
    always_comb begin
        delta   = $signed({v[IR_W-1], v}) - $signed({err[IR_W-1], err});
        step    = delta >>> FILT_SHIFT;
        err_nxt = IR_W'($signed({err[IR_W-1], err}) + step);
    end
`else
    always_comb begin
        err_nxt = v;
    end
`endif

    always_ff @(posedge clk) begin
        if (load) begin
            r_snap[0] <= IR_R0;
            r_snap[1] <= IR_R1;
            r_snap[2] <= IR_R2;
            r_snap[3] <= IR_R3;
            l_snap[0] <= IR_L0;
            l_snap[1] <= IR_L1;
            l_snap[2] <= IR_L2;
            l_snap[3] <= IR_L3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            idx       <= '0;
            err       <= '0;
            err_vld   <= 1'b0;
            ovr       <= 1'b0;
            last_sign <= 1'b0;
        end else begin
            err_vld <= 1'b0;
            if (IR_vld && busy) begin
                ovr <= 1'b1;
            end
            if (load) begin
                acc <= '0;
                idx <= '0;
            end
            if (state == ACCUM) begin
                acc <= acc + term;
                idx <= idx + 2'd1;
            end
            if (state == FINAL) begin
                err     <= err_nxt;
                err_vld <= 1'b1;
                // A zero result carries no direction, so keep the previous side.
                if (line_present && (sat != '0)) begin
                    last_sign <= sat[IR_W-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_err_calc.sv
module tb_ir_err_calc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IR_vld;
    logic        line_present;
    logic [11:0] rr [4];
    logic [11:0] ll [4];
    logic [11:0] err;
    logic        err_vld;
    logic        busy;
    logic        ovr;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_err  = 0;
    int m_sign = 0;

    always #5 clk = ~clk;

    ir_err_calc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IR_vld       (IR_vld),
        .line_present (line_present),
        .IR_R0        (rr[0]),
        .IR_R1        (rr[1]),
        .IR_R2        (rr[2]),
        .IR_R3        (rr[3]),
        .IR_L0        (ll[0]),
        .IR_L1        (ll[1]),
        .IR_L2        (ll[2]),
        .IR_L3        (ll[3]),
        .err          (err),
        .err_vld      (err_vld),
        .busy         (busy),
        .ovr          (ovr)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_all(input int r0, input int r1, input int r2, input int r3,
                           input int l0, input int l1, input int l2, input int l3);
        rr[0] = 12'(r0); rr[1] = 12'(r1); rr[2] = 12'(r2); rr[3] = 12'(r3);
        ll[0] = 12'(l0); ll[1] = 12'(l1); ll[2] = 12'(l2); ll[3] = 12'(l3);
    endtask

    // Expected err from the current readings, straight from the arithmetic rules.
    function automatic int model_next(input bit lp);
        int s, sat, v;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += (int'(rr[i]) - int'(ll[i])) * (1 << i);
        end
        sat = (s > 2047) ? 2047 : ((s < -2048) ? -2048 : s);
        if (lp) begin
            v = sat;
            if (sat != 0) m_sign = (sat < 0) ? 1 : 0;
        end else begin
            v = m_sign ? -1536 : 1536;
        end
`ifdef ERR_FILT_EN
        m_err = m_err + ((v - m_err) >>> 2);
`else
        m_err = v;
`endif
        return m_err;
    endfunction

    // One full round; extra_at (1..5) injects a second IR_vld before that edge.
    task automatic run_round(input bit lp, input int extra_at, input string tag);
        int exp;
        exp = model_next(lp);
        IR_vld       = 1'b1;
        line_present = lp;
        @(posedge clk); #1;
        IR_vld = 1'b0;
        check({tag, "_busy0"}, int'(busy), 1);
        for (int k = 1; k <= 5; k++) begin
            if (k == extra_at) begin
                IR_vld = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    rr[i] = 12'($urandom);
                    ll[i] = 12'($urandom);
                end
            end
            @(posedge clk); #1;
            IR_vld = 1'b0;
            if (k < 5) begin
                check({tag, "_vld_early"}, int'(err_vld), 0);
                check({tag, "_busy_mid"}, int'(busy), 1);
            end else begin
                check({tag, "_vld"}, int'(err_vld), 1);
                check({tag, "_busy_end"}, int'(busy), 0);
                check({tag, "_err"}, int'($signed(err)), exp);
            end
        end
        @(posedge clk); #1;
        check({tag, "_vld_once"}, int'(err_vld), 0);
        check({tag, "_idle"}, int'(busy), 0);
        check({tag, "_err_hold"}, int'($signed(err)), exp);
        if (extra_at != 0) check({tag, "_ovr"}, int'(ovr), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_err  = 0;
        m_sign = 0;
    endtask

    initial begin
        rst_n        = 1'b0;
        IR_vld       = 1'b0;
        line_present = 1'b1;
        set_all(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        check("rst_err", int'($signed(err)), 0);
        check("rst_vld", int'(err_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(ovr), 0);

        // lost line straight out of reset: positive recovery magnitude
        set_all(5, 0, 0, 0, 0, 0, 0, 0);
        run_round(1'b0, 0, "lost_rst");

        // balanced readings
        set_all('h400, 'h400, 'h400, 'h400, 'h400, 'h400, 'h400, 'h400);
        run_round(1'b1, 0, "t1_zero");

        // single inner sensors, both sides
        set_all('h010, 0, 0, 0, 0, 0, 0, 0);
        run_round(1'b1, 0, "t2_pos");
        set_all(0, 0, 0, 0, 0, 'h020, 0, 0);
        run_round(1'b1, 0, "t2_neg");

        // saturation at both limits
        set_all('hFFF, 0, 0, 0, 0, 0, 0, 0);
        set_all(0, 0, 0, 'hFFF, 0, 0, 0, 0);
        run_round(1'b1, 0, "t3_hi");
        set_all(0, 0, 0, 0, 'hFFF, 'hFFF, 'hFFF, 'hFFF);
        run_round(1'b1, 0, "t3_lo");

        // lost line after positive and negative valid errors
        set_all(100, 0, 0, 0, 0, 0, 0, 0);
        run_round(1'b1, 0, "t4_p100");
        run_round(1'b0, 0, "t4_lost_pos");
        set_all(0, 0, 0, 0, 0, 'h020, 0, 0);
        run_round(1'b1, 0, "t4_m64");
        run_round(1'b0, 0, "t4_lost_neg");

        // zero result keeps the previous side for lost-line recovery
        set_all(0, 0, 0, 0, 0, 0, 0, 0);
        run_round(1'b1, 0, "zero_keep");
        run_round(1'b0, 0, "zero_lost");

        // randomized rounds against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                rr[i] = 12'($urandom);
                ll[i] = 12'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) ll[i] = 12'($urandom_range(0, 64));
            end else if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 4; i++) rr[i] = 12'($urandom_range(0, 64));
            end
            run_round(($urandom_range(0, 4) != 0), 0, "rand");
        end
        check("ovr_clear", int'(ovr), 0);

        // IR_vld on the err-load edge is an overrun and does not restart
        set_all(7, 0, 0, 0, 0, 3, 0, 0);
        run_round(1'b1, 5, "ovr_edge5");

        // mid-computation overrun: snapshot untouched, single strobe
        do_reset();
        check("rst2_ovr", int'(ovr), 0);
        set_all(0, 0, 'h123, 0, 0, 'h050, 0, 0);
        run_round(1'b1, 2, "t5_ovr");

        // reset during ACCUM abandons the round
        set_all('h300, 0, 0, 0, 0, 0, 0, 0);
        IR_vld = 1'b1;
        @(posedge clk); #1;
        IR_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_err  = 0;
        m_sign = 0;
        check("midrst_err", int'($signed(err)), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ovr", int'(ovr), 0);
        for (int k = 0; k < 6; k++) begin
            check("midrst_novld", int'(err_vld), 0);
            @(posedge clk); #1;
        end
        check("midrst_idle", int'(busy), 0);

        // normal operation resumes after the abandoned round
        set_all(0, 'h040, 0, 0, 0, 0, 0, 0);
        run_round(1'b1, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
